count_seq_checker: RTL and testbench
====================================

Name: count_seq_checker

Overview:
- Downstream monitor for the 3-bit up/Gray mode counter.
- Samples `count` and `mode` every clock and checks that each new `count` is the legal successor of the previous one under the `mode` that was applied.
- Reports per-step legality, a sticky error, a saturating error count, and a wrap pulse at each sequence wrap.
- Provides the position within the sequence as a binary index.
- Sits beside the counter on the same clock; purely observational, with no feedback into the counter.

Parameters:
- ERR_W, 8, width of the saturating error counter `err_count`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- mode  input  1  same net that drives the counter; 0 = binary up, 1 = Gray sequence
- count  input  3  counter output, bit 2 = A (MSB), bit 0 = C
- valid  output  1  high once a previous sample exists and `step_ok` is meaningful
- step_ok  output  1  last observed transition was legal (registered)
- err  output  1  sticky: set by any illegal transition, cleared only by reset
- err_count  output  ERR_W  number of illegal transitions, saturating at all-ones
- wrap  output  1  one-cycle pulse when a legal transition returned `count` to 0
- index  output  3  position of the current `count` in the active sequence (see Optional Feature)

Behaviour:
- Successor function succ(v,m):
  - m=0: (v+1) mod 8, giving 0,1,2,3,4,5,6,7,0.
  - m=1: Gray sequence 0→1→3→2→6→7→5→4→0.
  - Implement as a constant lookup; no arithmetic beyond 3-bit wrap.
- Internal registers: `prev_count[2:0]`, `prev_mode`, and FSM state {S_ARM, S_TRACK}.
- Reset, while `reset`=1 at an edge:
  - state=S_ARM.
  - `prev_count`=0, `prev_mode`=0.
  - `valid`=0, `step_ok`=0, `err`=0, `err_count`=0, `wrap`=0, `index`=0.
  - Reset mid-operation discards all history and counts.
- S_ARM, first non-reset edge:
  - Capture `prev_count`<=`count`, `prev_mode`<=`mode`.
  - Go to S_TRACK.
  - `valid` stays 0 and no check is performed.
- S_TRACK, every edge:
  - `ok` = (`count` == succ(`prev_count`, `prev_mode`)).
  - `step_ok`<=`ok`; `valid`<=1.
  - If !`ok`: `err`<=1 and `err_count`<=`err_count`+1 unless already all-ones.
  - `wrap`<=`ok` & (`count`==0).
  - Then `prev_count`<=`count`, `prev_mode`<=`mode`.
- Latency: a transition landing on edge k (counter side) is reported on `step_ok` after edge k+1. This is one cycle of registered latency.
- Mode change: the check always uses the mode sampled on the previous edge. This matches the counter, which uses `mode` at the edge it advances.
  - Example: `count`=3 with `mode` switching 0→1 at edge k gives an expected value of 2 at edge k+1.
- Resynchronisation after an error: the illegal value becomes the new `prev_count`. Checking continues from it with no extra error. A single glitch therefore costs exactly 1 count per wrong transition.
- `wrap` never asserts on an illegal transition to 0. This includes 5→0 under mode 0.
- `err_count` saturates; it never wraps to 0.
- Outputs are all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CHK_GRAY_INDEX_EN.
- Defined: `index` is registered on the same edge as `step_ok`.
  - `index` = `count` when the sampled `mode`=0.
  - `index` = Gray-to-binary of `count` when `mode`=1: 0→0, 1→1, 3→2, 2→3, 6→4, 7→5, 5→6, 4→7.
- Not defined: `index` = registered `count` regardless of mode, and no decoding logic is generated.
- Reset value of `index` is 0 in both builds.

Test Plan:
- Reset 3 cycles, then count 0..7,0 with mode=0 → `valid` rises one cycle after the first sample; `step_ok`=1 every cycle; `wrap` pulses once after 7→0; `err`=0; `err_count`=0.
- Mode=1 with count 0,1,3,2,6,7,5,4,0 → `step_ok`=1 throughout; `wrap` pulses once; with CHK_GRAY_INDEX_EN, `index` = 0,1,2,3,4,5,6,7,0.
- Mode switch mid-stream: count 0,1,2,3 under mode 0, mode→1 on the edge leaving 3, next count 2, then 6 → all `step_ok`=1; feeding 4 instead of 2 → `step_ok`=0, `err`=1, `err_count`=1.
- Glitch 2,5,6 under mode 0 → one error at 2→5; 5→6 is legal after resync; `err_count`=1 and `err` stays 1 afterwards.
- ERR_W=2 with 5 consecutive illegal steps → `err_count` goes 1,2,3,3,3.
- Assert `reset` for one cycle mid-stream with `err`=1 → all outputs 0 next cycle; `valid`=0 for one further cycle (S_ARM), then checking resumes.

Source files
------------

// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if
//   Bundles the counter-side observation signals and the checker results.
//   The master side (counter / environment) drives mode and count and reads
//   the results; the slave side (checker) samples mode and count and drives
//   the results.
//   Signals:
//     mode      - 0 = binary up, 1 = Gray sequence
//     count     - observed counter value, bit 2 is the MSB
//     valid     - a previous sample exists and step_ok is meaningful
//     step_ok   - last observed transition was legal
//     err       - sticky illegal-transition flag
//     err_count - saturating count of illegal transitions
//     wrap      - one-cycle pulse on a legal return to 0
//     index     - position of the current count within its sequence
interface count_seq_checker_if #(
    parameter int ERR_W = 8
) ();
    logic             mode;
    logic [2:0]       count;
    logic             valid;
    logic             step_ok;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic             wrap;
    logic [2:0]       index;

    modport master (
        output mode, count,
        input  valid, step_ok, err, err_count, wrap, index
    );

    modport slave (
        input  mode, count,
        output valid, step_ok, err, err_count, wrap, index
    );
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Passive monitor for the 3-bit up/Gray counter. Each clock it checks that
//   the new count is the legal successor of the previously sampled count,
//   using the mode sampled with that previous count. After an illegal value
//   the checker resynchronises on it, so one glitch costs one error per
//   wrong transition. All outputs are registered.
//   Ports:
//     clk   - system clock, rising edge
//     reset - synchronous, active-high
//     bus   - count_seq_checker_if.slave (mode/count in, results out)
//   Parameters:
//     ERR_W - width of the saturating error counter
//   Build option:
//     CHK_GRAY_INDEX_EN - when defined, index is the Gray-to-binary position
//     under mode 1; otherwise index is simply the registered count.
//
//   state   | meaning
//   S_ARM   | no previous sample yet; next edge captures one, no check
//   S_TRACK | previous sample held; every edge checks count against it
module count_seq_checker #(
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    count_seq_checker_if.slave bus
);
    typedef enum logic {S_ARM, S_TRACK} state_t;

    state_t           state, state_n;
    logic [2:0]       prev_count, prev_count_n;
    logic             prev_mode, prev_mode_n;
    logic             valid_q, valid_n;
    logic             step_ok_q, step_ok_n;
    logic             err_q, err_n;
    logic [ERR_W-1:0] err_count_q, err_count_n;
    logic             wrap_q, wrap_n;
    logic [2:0]       index_q, index_n;
    logic [2:0]       expected;
    logic             ok;

    // Successor lookup: {mode, value} -> next value.
    function automatic logic [2:0] succ(input logic [2:0] v, input logic m);
        logic [2:0] r;
        r = 3'd0;
        case ({m, v})
            4'b0_000: r = 3'd1;
            4'b0_001: r = 3'd2;
            4'b0_010: r = 3'd3;
            4'b0_011: r = 3'd4;
            4'b0_100: r = 3'd5;
            4'b0_101: r = 3'd6;
            4'b0_110: r = 3'd7;
            4'b0_111: r = 3'd0;
            4'b1_000: r = 3'd1;
            4'b1_001: r = 3'd3;
            4'b1_011: r = 3'd2;
            4'b1_010: r = 3'd6;
            4'b1_110: r = 3'd7;
            4'b1_111: r = 3'd5;
            4'b1_101: r = 3'd4;
            4'b1_100: r = 3'd0;
            default:  r = 3'd0;
        endcase
        return r;
    endfunction

`ifdef CHK_GRAY_INDEX_EN
    function automatic logic [2:0] gray_pos(input logic [2:0] g);
        logic [2:0] r;
        r = 3'd0;
        case (g)
            3'd0: r = 3'd0;
            3'd1: r = 3'd1;
            3'd3: r = 3'd2;
            3'd2: r = 3'd3;
            3'd6: r = 3'd4;
            3'd7: r = 3'd5;
            3'd5: r = 3'd6;
            3'd4: r = 3'd7;
            default: r = 3'd0;
        endcase
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_ARM;
            prev_count  <= 3'd0;
            prev_mode   <= 1'b0;
            valid_q     <= 1'b0;
            step_ok_q   <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            wrap_q      <= 1'b0;
            index_q     <= 3'd0;
        end else begin
            state       <= state_n;
            prev_count  <= prev_count_n;
            prev_mode   <= prev_mode_n;
            valid_q     <= valid_n;
            step_ok_q   <= step_ok_n;
            err_q       <= err_n;
            err_count_q <= err_count_n;
            wrap_q      <= wrap_n;
            index_q     <= index_n;
        end
    end

    always_comb begin
        state_n      = state;
        prev_count_n = bus.count;
        prev_mode_n  = bus.mode;
        valid_n      = valid_q;
        step_ok_n    = step_ok_q;
        err_n        = err_q;
        err_count_n  = err_count_q;
        wrap_n       = 1'b0;
        expected     = succ(prev_count, prev_mode);
        ok           = (bus.count == expected);
`ifdef CHK_GRAY_INDEX_EN
        index_n      = bus.mode ? gray_pos(bus.count) : bus.count;
`else
        index_n      = bus.count;
`endif

        case (state)
            S_ARM: begin
                state_n = S_TRACK;
            end
            S_TRACK: begin
                valid_n   = 1'b1;
                step_ok_n = ok;
                wrap_n    = ok && (bus.count == 3'd0);
                if (!ok) begin
                    err_n = 1'b1;
                    if (err_count_q != {ERR_W{1'b1}}) begin
                        err_count_n = err_count_q + 1'b1;
                    end
                end
            end
            default: state_n = S_ARM;
        endcase
    end

    assign bus.valid     = valid_q;
    assign bus.step_ok   = step_ok_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
    assign bus.wrap      = wrap_q;
    assign bus.index     = index_q;
endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    count_seq_checker_if #(.ERR_W(8)) bus_a ();
    count_seq_checker_if #(.ERR_W(2)) bus_b ();

    count_seq_checker #(.ERR_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    count_seq_checker #(.ERR_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Reference model: sequences as ordered lists, history as "last sample".
    int seq_up[8]   = '{0, 1, 2, 3, 4, 5, 6, 7};
    int seq_gray[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    bit m_has_prev;
    int m_pc, m_pm;
    bit m_valid, m_ok, m_err, m_wrap;
    int m_cnt8, m_cnt2, m_idx;
    int last_c, last_m;

    function automatic int pos_in(int v, int m);
        for (int i = 0; i < 8; i++) begin
            if ((m == 0 && seq_up[i] == v) || (m == 1 && seq_gray[i] == v)) return i;
        end
        return 0;
    endfunction

    function automatic int next_of(int v, int m);
        int p;
        p = (pos_in(v, m) + 1) % 8;
        return (m == 0) ? seq_up[p] : seq_gray[p];
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(int r, int c, int m);
        bit good;
        if (r != 0) begin
            m_has_prev = 0; m_pc = 0; m_pm = 0;
            m_valid = 0; m_ok = 0; m_err = 0; m_wrap = 0;
            m_cnt8 = 0; m_cnt2 = 0; m_idx = 0;
            return;
        end
`ifdef CHK_GRAY_INDEX_EN
        m_idx = (m == 1) ? pos_in(c, 1) : c;
`else
        m_idx = c;
`endif
        if (!m_has_prev) begin
            m_has_prev = 1;
            m_wrap = 0;
        end else begin
            good    = (c == next_of(m_pc, m_pm));
            m_valid = 1;
            m_ok    = good;
            m_wrap  = good && (c == 0);
            if (!good) begin
                m_err = 1;
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        m_pc = c;
        m_pm = m;
    endtask

    // Called at a negedge: drive, take the edge, compare at the next negedge.
    task automatic cycle(int r, int c, int m);
        reset       = (r != 0);
        bus_a.count = 3'(c); bus_a.mode = m[0];
        bus_b.count = 3'(c); bus_b.mode = m[0];
        last_c = c; last_m = m;
        @(posedge clk);
        model_edge(r, c, m);
        @(negedge clk);
        chk("valid",     int'(bus_a.valid),     int'(m_valid));
        chk("step_ok",   int'(bus_a.step_ok),   int'(m_ok));
        chk("err",       int'(bus_a.err),       int'(m_err));
        chk("err_count", int'(bus_a.err_count), m_cnt8);
        chk("wrap",      int'(bus_a.wrap),      int'(m_wrap));
        chk("index",     int'(bus_a.index),     m_idx);
        chk("err2",      int'(bus_b.err),       int'(m_err));
        chk("err_count2",int'(bus_b.err_count), m_cnt2);
        chk("wrap2",     int'(bus_b.wrap),      int'(m_wrap));
    endtask

    int up_run[9]   = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int gray_run[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};

    initial begin
        int c, m, k;
        reset = 1'b1;
        bus_a.count = 3'd0; bus_a.mode = 1'b0;
        bus_b.count = 3'd0; bus_b.mode = 1'b0;
        @(negedge clk);

        // Reset, then a full binary run.
        repeat (3) cycle(1, 0, 0);
        foreach (up_run[i]) cycle(0, up_run[i], 0);

        // Full Gray run (first step 0->0 under prior mode 0 is an error; reset first).
        cycle(1, 0, 1);
        foreach (gray_run[i]) cycle(0, gray_run[i], 1);

        // Mode switch mid-stream: legal path 3 -> 2 -> 6.
        cycle(1, 0, 0);
        cycle(0, 0, 0); cycle(0, 1, 0); cycle(0, 2, 0); cycle(0, 3, 1);
        cycle(0, 2, 1); cycle(0, 6, 1);
        // Same switch but feed 4 instead of 2.
        cycle(1, 0, 0);
        cycle(0, 0, 0); cycle(0, 1, 0); cycle(0, 2, 0); cycle(0, 3, 1);
        cycle(0, 4, 1); cycle(0, 0, 1);

        // Glitch 2,5,6 under binary mode, then continue.
        cycle(1, 0, 0);
        cycle(0, 1, 0); cycle(0, 2, 0); cycle(0, 5, 0); cycle(0, 6, 0); cycle(0, 7, 0);
        // Illegal 5->0 must not wrap.
        cycle(0, 5, 0); cycle(0, 0, 0);

        // Five illegal steps: saturates the narrow counter.
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        repeat (5) cycle(0, 0, 0);

        // One-cycle reset mid-stream with err set, then re-arm and resume.
        cycle(1, 0, 0);
        cycle(0, 4, 0); cycle(0, 5, 0); cycle(0, 6, 0);

        // Randomized traffic: mostly legal steps, occasional glitches, mode flips, resets.
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 99);
            m = last_m;
            if ($urandom_range(0, 7) == 0) m = 1 - m;
            if (k < 2) begin
                cycle(1, $urandom_range(0, 7), m);
            end else if (k < 12) begin
                cycle(0, $urandom_range(0, 7), m);
            end else begin
                c = next_of(last_c, last_m);
                cycle(0, c, m);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
